// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Common-data-bus arbiter. Merges N_CH result producers (ALU, LSB, MUL/DIV...)
//   onto one registered broadcast bus for ROB/RS/LSB/RF. Each channel has its
//   own FIFO, and grants rotate round-robin starting at rr_ptr. A branch
//   mispredict (br_flag) flushes every buffered result.
//
//   Optional feature macro: CDB_ARB_BYPASS_EN
//     defined   : an empty channel with a valid input is eligible in the same
//                 cycle. If it is granted, the input goes straight to the
//                 output registers (1-cycle latency). If it is not granted, the
//                 input is pushed into the FIFO as usual.
//     undefined : every result passes through its FIFO (minimum latency 2).
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   en              ready; low freezes all state and ignores src_en_i
//   br_flag         mispredict flush (priority over push and pop)
//   src_en_i        per-channel result valid
//   src_q_i         per-channel ROB tag (channel k at [k*ROB_W +: ROB_W])
//   src_v_i         per-channel result value
//   src_cbr_i       per-channel branch-taken flag
//   src_cbt_i       per-channel branch target
//   src_full_o      per-channel backpressure (count >= FIFO_DEP-1), combinational
//   cdb_en_o        broadcast valid
//   cdb_q_o/v_o/cbr_o/cbt_o  broadcast payload
//   cdb_ch_o        granted channel index (debug)
//   ovf_o           sticky: a push hit a full FIFO
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_CH     = 2,
  parameter int FIFO_DEP = 4,
  parameter int ROB_W    = 4,
  parameter int DAT_W    = 32,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    br_flag,
  input  logic [N_CH-1:0]         src_en_i,
  input  logic [N_CH*ROB_W-1:0]   src_q_i,
  input  logic [N_CH*DAT_W-1:0]   src_v_i,
  input  logic [N_CH-1:0]         src_cbr_i,
  input  logic [N_CH*DAT_W-1:0]   src_cbt_i,
  output logic [N_CH-1:0]         src_full_o,
  output logic                    cdb_en_o,
  output logic [ROB_W-1:0]        cdb_q_o,
  output logic [DAT_W-1:0]        cdb_v_o,
  output logic                    cdb_cbr_o,
  output logic [DAT_W-1:0]        cdb_cbt_o,
  output logic [CH_W-1:0]         cdb_ch_o,
  output logic                    ovf_o
);

  localparam int PTR_W = $clog2(FIFO_DEP);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_W-1:0] q;
    logic [DAT_W-1:0] v;
    logic             cbr;
    logic [DAT_W-1:0] cbt;
  } entry_t;

  entry_t            mem    [N_CH][FIFO_DEP];
  logic [PTR_W-1:0]  wr_ptr [N_CH];
  logic [PTR_W-1:0]  rd_ptr [N_CH];
  logic [CNT_W-1:0]  count  [N_CH];
  logic [CH_W-1:0]   rr_ptr;

  entry_t            src_ent [N_CH];
  logic [N_CH-1:0]   byp_ok;
  logic [N_CH-1:0]   eligible;
  logic [N_CH-1:0]   push;
  logic [N_CH-1:0]   pop;
  logic [N_CH-1:0]   wr_acc;
  logic [N_CH-1:0]   drop;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   rr_nxt;
  entry_t            gnt_ent;
  logic              advance;

  // State only moves when enabled and not flushing.
  assign advance = en && !br_flag;

  // Unpack the flat input buses and derive per-channel eligibility.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      src_ent[k].q   = src_q_i[k*ROB_W +: ROB_W];
      src_ent[k].v   = src_v_i[k*DAT_W +: DAT_W];
      src_ent[k].cbr = src_cbr_i[k];
      src_ent[k].cbt = src_cbt_i[k*DAT_W +: DAT_W];
`ifdef CDB_ARB_BYPASS_EN
      byp_ok[k]      = (count[k] == '0) && src_en_i[k];
`else
      byp_ok[k]      = 1'b0;
`endif
      eligible[k]    = (count[k] != '0) || byp_ok[k];
      src_full_o[k]  = count[k] >= CNT_W'(FIFO_DEP - 1);
    end
  end

  // Round-robin search: first eligible channel at rr_ptr, rr_ptr+1, ... mod N_CH.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
    rr_nxt = (int'(gnt_ch) == N_CH - 1) ? '0 : gnt_ch + CH_W'(1);
  end

  // Per-channel push/pop decisions. A bypass-granted input never enters the
  // FIFO. A push into a FIFO holding FIFO_DEP entries is dropped even if the
  // same FIFO is popped this cycle.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      push[k]   = src_en_i[k] && !(gnt_vld && int'(gnt_ch) == k && byp_ok[k]);
      pop[k]    = advance && gnt_vld && int'(gnt_ch) == k && (count[k] != '0);
      drop[k]   = advance && push[k] && (count[k] == CNT_W'(FIFO_DEP));
      wr_acc[k] = advance && push[k] && (count[k] != CNT_W'(FIFO_DEP));
    end
    gnt_ent = byp_ok[gnt_ch] ? src_ent[gnt_ch] : mem[gnt_ch][rd_ptr[gnt_ch]];
  end

  // NOTE: FIFO storage is deliberately left out of reset; the counts alone
  // define validity, so stale payload is never observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (wr_acc[k]) mem[k][wr_ptr[k]] <= src_ent[k];
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational blocks above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
      rr_ptr    <= '0;
      cdb_en_o  <= 1'b0;
      cdb_q_o   <= '0;
      cdb_v_o   <= '0;
      cdb_cbr_o <= 1'b0;
      cdb_cbt_o <= '0;
      cdb_ch_o  <= '0;
      ovf_o     <= 1'b0;
    end else if (en) begin
      if (br_flag) begin
        // Flush: drop buffered and same-cycle results, restart rotation at 0.
        for (int k = 0; k < N_CH; k++) begin
          wr_ptr[k] <= '0;
          rd_ptr[k] <= '0;
          count[k]  <= '0;
        end
        rr_ptr   <= '0;
        cdb_en_o <= 1'b0;
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          if (wr_acc[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
          if (pop[k])    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
          count[k] <= count[k] + CNT_W'(wr_acc[k]) - CNT_W'(pop[k]);
        end
        if (|drop) ovf_o <= 1'b1;
        if (gnt_vld) begin
          cdb_en_o  <= 1'b1;
          cdb_q_o   <= gnt_ent.q;
          cdb_v_o   <= gnt_ent.v;
          cdb_cbr_o <= gnt_ent.cbr;
          cdb_cbt_o <= gnt_ent.cbt;
          cdb_ch_o  <= gnt_ch;
          rr_ptr    <= rr_nxt;
        end else begin
          cdb_en_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N_CH = 2;
  localparam int FD   = 4;
  localparam int RW   = 4;
  localparam int DW   = 32;
  localparam int CW   = 1;

  logic              clk, rst, en, br_flag;
  logic [N_CH-1:0]   src_en_i;
  logic [N_CH*RW-1:0] src_q_i;
  logic [N_CH*DW-1:0] src_v_i;
  logic [N_CH-1:0]   src_cbr_i;
  logic [N_CH*DW-1:0] src_cbt_i;
  logic [N_CH-1:0]   src_full_o;
  logic              cdb_en_o;
  logic [RW-1:0]     cdb_q_o;
  logic [DW-1:0]     cdb_v_o;
  logic              cdb_cbr_o;
  logic [DW-1:0]     cdb_cbt_o;
  logic [CW-1:0]     cdb_ch_o;
  logic              ovf_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [RW-1:0] q;
    logic [DW-1:0] v;
    logic          cbr;
    logic [DW-1:0] cbt;
  } bc_t;

  bc_t log_q[$];

  cdb_arbiter #(.N_CH(N_CH), .FIFO_DEP(FD), .ROB_W(RW), .DAT_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .br_flag(br_flag),
    .src_en_i(src_en_i), .src_q_i(src_q_i), .src_v_i(src_v_i),
    .src_cbr_i(src_cbr_i), .src_cbt_i(src_cbt_i), .src_full_o(src_full_o),
    .cdb_en_o(cdb_en_o), .cdb_q_o(cdb_q_o), .cdb_v_o(cdb_v_o),
    .cdb_cbr_o(cdb_cbr_o), .cdb_cbt_o(cdb_cbt_o), .cdb_ch_o(cdb_ch_o),
    .ovf_o(ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Broadcast log, sampled on the falling edge.
  always @(negedge clk) begin
    if (cdb_en_o) log_q.push_back({cdb_ch_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o});
  end

  // Payload model: result i of channel ch.
  function automatic logic [RW-1:0] f_q(int ch, int i);
    return RW'(ch * 8 + i);
  endfunction
  function automatic logic [DW-1:0] f_v(int ch, int i);
    return 32'hA000_0000 | DW'(ch << 8) | DW'(i);
  endfunction
  function automatic logic f_cbr(int ch, int i);
    return ((ch ^ i) & 1) != 0;
  endfunction
  function automatic logic [DW-1:0] f_cbt(int ch, int i);
    return ~f_v(ch, i);
  endfunction
  function automatic bc_t mk_bc(int ch, int i);
    return {CW'(ch), f_q(ch, i), f_v(ch, i), f_cbr(ch, i), f_cbt(ch, i)};
  endfunction

  task automatic idle_inputs();
    src_en_i = '0; src_q_i = '0; src_v_i = '0; src_cbr_i = '0; src_cbt_i = '0;
  endtask

  task automatic drive(int ch, int i);
    src_en_i[ch]          = 1'b1;
    src_q_i[ch*RW +: RW]  = f_q(ch, i);
    src_v_i[ch*DW +: DW]  = f_v(ch, i);
    src_cbr_i[ch]         = f_cbr(ch, i);
    src_cbt_i[ch*DW +: DW] = f_cbt(ch, i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    br_flag = 1'b0;
    en      = 1'b1;
    rst     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    log_q.delete();
  endtask

  task automatic test_reset();
    logic [N_CH+2*DW+RW+CW+3-1:0] all_out;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    all_out = {src_full_o, cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_ch_o, ovf_o};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int lat;
`ifdef CDB_ARB_BYPASS_EN
    lat = 1;
`else
    lat = 2;
`endif
    do_reset();
    src_en_i[0] = 1'b1;
    src_q_i[RW-1:0] = 4'd3;
    src_v_i[DW-1:0] = 32'h1234;
    src_cbr_i[0] = 1'b1;
    src_cbt_i[DW-1:0] = 32'hBEEF;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      idle_inputs();
      checks++;
      if (cdb_en_o !== (c == lat)) begin
        errors++;
        $display("FAIL single_en c%0d: got %b expected %b", c, cdb_en_o, (c == lat));
      end
      if (c >= lat) begin
        checks++;
        if ({cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_ch_o} !== {4'd3, 32'h1234, 1'b1, 32'hBEEF, 1'b0}) begin
          errors++;
          $display("FAIL single_data c%0d: got q=%h v=%h cbr=%b cbt=%h ch=%h expected q=3 v=1234 cbr=1 cbt=beef ch=0",
                   c, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_ch_o);
        end
      end
    end
  endtask

  task automatic test_contention();
    int exp_ch[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp_i [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    bc_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (src_full_o !== 2'b00) begin
          errors++;
          $display("FAIL contention_full_c2: got %b expected 00", src_full_o);
        end
      end
      idle_inputs();
      drive(0, i);
      drive(1, i);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (src_full_o !== 2'b10) begin
      errors++;
      $display("FAIL contention_full_c3: got %b expected 10", src_full_o);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (log_q.size() !== 8) begin
      errors++;
      $display("FAIL contention_count: got %0d expected 8", log_q.size());
    end
    for (int j = 0; j < 8 && j < log_q.size(); j++) begin
      e = mk_bc(exp_ch[j], exp_i[j]);
      checks++;
      if (log_q[j] !== e) begin
        errors++;
        $display("FAIL contention_bc%0d: got %h expected %h", j, log_q[j], e);
      end
    end
  endtask

  task automatic test_overflow();
    int exp_ch[14] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int exp_i [14] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 7};
    bc_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 6) begin
        checks++;
        if (ovf_o !== 1'b0) begin
          errors++;
          $display("FAIL ovf_before: got %b expected 0", ovf_o);
        end
      end
      if (i == 7) begin
        checks++;
        if ({ovf_o, src_full_o} !== 3'b111) begin
          errors++;
          $display("FAIL ovf_set: got ovf=%b full=%b expected ovf=1 full=11", ovf_o, src_full_o);
        end
      end
      idle_inputs();
      drive(0, i);
      drive(1, i);
    end
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    checks++;
    if (ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", ovf_o);
    end
    checks++;
    if (log_q.size() !== 14) begin
      errors++;
      $display("FAIL ovf_count: got %0d expected 14", log_q.size());
    end
    for (int j = 0; j < 14 && j < log_q.size(); j++) begin
      e = mk_bc(exp_ch[j], exp_i[j]);
      checks++;
      if (log_q[j] !== e) begin
        errors++;
        $display("FAIL ovf_bc%0d: got %h expected %h", j, log_q[j], e);
      end
    end
  endtask

  // Runs straight after test_overflow so ovf_o is set going in.
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      drive(0, i);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if ({cdb_en_o, ovf_o} !== 2'b11) begin
      errors++;
      $display("FAIL areset_pre: got en=%b ovf=%b expected en=1 ovf=1", cdb_en_o, ovf_o);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_ch_o, ovf_o, src_full_o} !== '0) begin
      errors++;
      $display("FAIL areset_now: got en=%b q=%h v=%h ovf=%b full=%b expected all 0",
               cdb_en_o, cdb_q_o, cdb_v_o, ovf_o, src_full_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (cdb_en_o !== 1'b0) begin
        errors++;
        $display("FAIL areset_empty c%0d: got %b expected 0", c, cdb_en_o);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      drive(0, i);
    end
    @(negedge clk);
    idle_inputs();
    drive(0, 4);
    drive(1, 4);
    br_flag = 1'b1;
    @(negedge clk);
    br_flag = 1'b0;
    idle_inputs();
    checks++;
    if ({cdb_en_o, src_full_o} !== 3'b000) begin
      errors++;
      $display("FAIL flush_now: got en=%b full=%b expected en=0 full=00", cdb_en_o, src_full_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (log_q.size() !== 3) begin
      errors++;
      $display("FAIL flush_quiet: got %0d broadcasts expected 3", log_q.size());
    end
    drive(0, 5);
    drive(1, 5);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({cdb_en_o, cdb_ch_o, cdb_v_o} !== {1'b1, 1'b0, f_v(0, 5)}) begin
      errors++;
      $display("FAIL flush_rr0: got en=%b ch=%h v=%h expected en=1 ch=0 v=%h",
               cdb_en_o, cdb_ch_o, cdb_v_o, f_v(0, 5));
    end
    @(negedge clk);
    checks++;
    if ({cdb_en_o, cdb_ch_o, cdb_v_o} !== {1'b1, 1'b1, f_v(1, 5)}) begin
      errors++;
      $display("FAIL flush_rr1: got en=%b ch=%h v=%h expected en=1 ch=1 v=%h",
               cdb_en_o, cdb_ch_o, cdb_v_o, f_v(1, 5));
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(0, 0);
    @(negedge clk);
    idle_inputs();
    drive(0, 1);
    @(negedge clk);
    idle_inputs();
    en = 1'b0;
    drive(1, 9);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({cdb_en_o, cdb_ch_o, cdb_v_o} !== {1'b1, 1'b0, f_v(0, 0)}) begin
        errors++;
        $display("FAIL stall_hold c%0d: got en=%b ch=%h v=%h expected en=1 ch=0 v=%h",
                 c, cdb_en_o, cdb_ch_o, cdb_v_o, f_v(0, 0));
      end
      if (c < 5) @(negedge clk);
    end
    en = 1'b1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({cdb_en_o, cdb_ch_o, cdb_q_o, cdb_v_o} !== {1'b1, 1'b0, f_q(0, 1), f_v(0, 1)}) begin
      errors++;
      $display("FAIL stall_resume: got en=%b ch=%h q=%h v=%h expected en=1 ch=0 q=%h v=%h",
               cdb_en_o, cdb_ch_o, cdb_q_o, cdb_v_o, f_q(0, 1), f_v(0, 1));
    end
    @(negedge clk);
    checks++;
    if (cdb_en_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_drained: got %b expected 0", cdb_en_o);
    end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b1;
    br_flag = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_async_reset();
    test_flush();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog timeout");
  end

endmodule
